// File: rtl/nv_nvdla_sdp_mrdma_reqgen_p_if.sv
// MRDMA ingress request bus: DMA read request channel plus the matching context-queue channel.
interface nv_nvdla_sdp_mrdma_reqgen_p_if #(
    parameter int AW     = 64,
    parameter int SIZE_W = 15
);
    logic                   dma_rd_req_vld;
    logic                   dma_rd_req_rdy;
    logic [AW+SIZE_W-1:0]   dma_rd_req_pd;
    logic                   ig2cq_vld;
    logic                   ig2cq_rdy;
    logic [SIZE_W+1:0]      ig2cq_pd;

    modport master (
        output dma_rd_req_vld, dma_rd_req_pd, ig2cq_vld, ig2cq_pd,
        input  dma_rd_req_rdy, ig2cq_rdy
    );

    modport slave (
        input  dma_rd_req_vld, dma_rd_req_pd, ig2cq_vld, ig2cq_pd,
        output dma_rd_req_rdy, ig2cq_rdy
    );
endinterface

// File: rtl/nv_nvdla_sdp_mrdma_reqgen_p.sv
// SDP MRDMA ingress request generator: walks surface x line x width in atoms, merges atoms
// into line-bounded bursts and issues each request with a context entry under credit control.
module nv_nvdla_sdp_mrdma_reqgen_p #(
    parameter int AW        = 64,
    parameter int AM_AW     = 5,
    parameter int CNT_W     = 13,
    parameter int MAX_BURST = 8,
    parameter int MAX_OUTST = 16,
    parameter int SIZE_W    = 15
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rst,
    input  logic                  reg2dp_op_en,
    input  logic [CNT_W-1:0]      reg2dp_width,
    input  logic [CNT_W-1:0]      reg2dp_height,
    input  logic [CNT_W-1:0]      reg2dp_surface,
    input  logic [AW-AM_AW-1:0]   reg2dp_src_base_addr,
    input  logic [AW-AM_AW-1:0]   reg2dp_line_stride,
    input  logic [AW-AM_AW-1:0]   reg2dp_surf_stride,
    input  logic                  reg2dp_perf_dma_en,
    nv_nvdla_sdp_mrdma_reqgen_p_if.master req_if,
    input  logic                  dma_rd_cdt_lat_fifo_pop,
    input  logic                  eg_done,
    output logic                  layer_busy,
    output logic                  op_load,
    output logic [31:0]           dp2reg_mrdma_stall
);
    localparam int AA   = AW - AM_AW;
    localparam int CR_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W:0]  MB   = (CNT_W+1)'(MAX_BURST);
    localparam logic [CR_W-1:0] MAXC = CR_W'(MAX_OUTST);

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_WAIT} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_width, r_height, r_surface, r_h_cnt, r_s_cnt;
    logic [CNT_W:0]     r_w_pos;
    logic [AA-1:0]      r_line_stride, r_surf_stride;
    logic [AA-1:0]      r_req_addr, r_line_addr, r_surf_addr;
    logic [CR_W-1:0]    r_cred;
    logic [31:0]        r_stall;

    logic [CNT_W:0]     w_rem, w_burst;
    logic [SIZE_W-1:0]  w_size;
    logic               w_line_end, w_last_line, w_layer_end;
    logic               w_avail, w_req_vld, w_cq_vld, w_accept, w_pop;
    logic [AA-1:0]      w_line_nxt, w_surf_nxt;

    assign layer_busy = (r_state != S_IDLE);
    assign op_load    = reg2dp_op_en & ~layer_busy;
    assign w_pop      = dma_rd_cdt_lat_fifo_pop & (r_cred != '0);

    // Bursts are clipped to the remaining atoms of the current line.
    assign w_rem       = {1'b0, r_width} + (CNT_W+1)'(1) - r_w_pos;
    assign w_burst     = (w_rem > MB) ? MB : w_rem;
    assign w_size      = SIZE_W'(w_burst - (CNT_W+1)'(1));
    assign w_line_end  = (w_burst == w_rem);
    assign w_last_line = (r_h_cnt == r_height);
    assign w_layer_end = w_line_end & w_last_line & (r_s_cnt == r_surface);
    assign w_line_nxt  = r_line_addr + r_line_stride;
    assign w_surf_nxt  = r_surf_addr + r_surf_stride;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) r_state <= S_IDLE;
        else                r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (op_load) w_state_nxt = S_GEN;
            S_GEN:   if (w_accept && w_layer_end) w_state_nxt = S_WAIT;
            S_WAIT:  if (eg_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Each side's valid waits on the other's ready so both transfer in the same cycle.
    always_comb begin
        w_avail   = (r_state == S_GEN) && (r_cred < MAXC);
        w_req_vld = w_avail & req_if.ig2cq_rdy;
        w_cq_vld  = w_avail & req_if.dma_rd_req_rdy;
        w_accept  = w_avail & req_if.dma_rd_req_rdy & req_if.ig2cq_rdy;
    end

    assign req_if.dma_rd_req_vld = w_req_vld;
    assign req_if.dma_rd_req_pd  = {w_size, r_req_addr, {AM_AW{1'b0}}};
    assign req_if.ig2cq_vld      = w_cq_vld;
    assign req_if.ig2cq_pd       = {w_layer_end, w_line_end, w_size};
    assign dp2reg_mrdma_stall    = r_stall;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_width       <= '0;
            r_height      <= '0;
            r_surface     <= '0;
            r_line_stride <= '0;
            r_surf_stride <= '0;
            r_w_pos       <= '0;
            r_h_cnt       <= '0;
            r_s_cnt       <= '0;
            r_req_addr    <= '0;
            r_line_addr   <= '0;
            r_surf_addr   <= '0;
            r_cred        <= '0;
            r_stall       <= '0;
        end else begin
            if (op_load) begin
                r_width       <= reg2dp_width;
                r_height      <= reg2dp_height;
                r_surface     <= reg2dp_surface;
                r_line_stride <= reg2dp_line_stride;
                r_surf_stride <= reg2dp_surf_stride;
                r_w_pos       <= '0;
                r_h_cnt       <= '0;
                r_s_cnt       <= '0;
                r_req_addr    <= reg2dp_src_base_addr;
                r_line_addr   <= reg2dp_src_base_addr;
                r_surf_addr   <= reg2dp_src_base_addr;
            end else if (w_accept) begin
                if (!w_line_end) begin
                    r_w_pos    <= r_w_pos + w_burst;
                    r_req_addr <= r_req_addr + AA'(w_burst);
                end else begin
                    r_w_pos <= '0;
                    if (w_last_line) begin
                        r_h_cnt     <= '0;
                        r_s_cnt     <= r_s_cnt + CNT_W'(1);
                        r_surf_addr <= w_surf_nxt;
                        r_line_addr <= w_surf_nxt;
                        r_req_addr  <= w_surf_nxt;
                    end else begin
                        r_h_cnt     <= r_h_cnt + CNT_W'(1);
                        r_line_addr <= w_line_nxt;
                        r_req_addr  <= w_line_nxt;
                    end
                end
            end

            case ({w_accept, w_pop})
                2'b10:   r_cred <= r_cred + CR_W'(1);
                2'b01:   r_cred <= r_cred - CR_W'(1);
                default: r_cred <= r_cred;
            endcase

            if (op_load)
                r_stall <= '0;
            else if ((r_state == S_GEN) && !w_accept && reg2dp_perf_dma_en && (r_stall != 32'hFFFF_FFFF))
                r_stall <= r_stall + 32'd1;
        end
    end

    a_eg_done_in_gen: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(eg_done && (r_state == S_GEN)));
    a_pop_at_zero: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(dma_rd_cdt_lat_fifo_pop && (r_cred == '0)));
endmodule
